// File: rtl/ipsxe_fft_rdarb_pkg.sv
// Shared types and helpers for the FFT DRM read-port arbiter.
// Holds the FSM encoding, the default DRM read latency and the round-robin picker.
package ipsxe_fft_rdarb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } rdarb_state_e;

  localparam int RD_LATENCY_DRM = 2;
  localparam int RDARB_MAX_REQ  = 4;

  // One-hot pick of the first set bit of req at or after ptr, wrapping modulo num_req.
  function automatic logic [RDARB_MAX_REQ-1:0] rr_pick(
    input logic [RDARB_MAX_REQ-1:0] req,
    input logic [1:0]               ptr,
    input int                       num_req
  );
    logic [RDARB_MAX_REQ-1:0] pick;
    logic                     found;
    logic [2:0]               idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < RDARB_MAX_REQ; off++) begin
      if (off < num_req) begin
        idx = {1'b0, ptr} + 3'(off);
        if (idx >= 3'(num_req)) begin
          idx = idx - 3'(num_req);
        end
        if (!found && req[idx[1:0]]) begin
          pick[idx[1:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ipsxe_fft_rdarb_tagpipe.sv
// Read-latency tag pipeline: a DEPTH-deep {valid, id} shift register that
// advances in lockstep with the RAM array and its fabric output register.
module ipsxe_fft_rdarb_tagpipe #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 1
) (
  input  logic            rd_clk,
  input  logic            rd_rst,
  input  logic            adv,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic            any_valid
);

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    if (adv) begin
      valid_d[0] = in_valid;
      id_d[0]    = in_id;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        id_d[i]    = id_q[i-1];
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/ipsxe_fft_drm_rd_arbiter.sv
// Round-robin read-port arbiter for the FFT DRM buffer with burst locking;
// steers each returned RAM word back to the requester that issued it.
module ipsxe_fft_drm_rd_arbiter
  import ipsxe_fft_rdarb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 36,
  parameter int RD_LATENCY = RD_LATENCY_DRM,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  output logic                      ram_rd_clk_en,
  output logic                      ram_rd_oce,
  input  logic [DATA_W-1:0]         ram_rd_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output rdarb_state_e              dbg_state,
  output logic [ID_W-1:0]           dbg_ptr
);

  // Handshake: requester i transfers a beat in any cycle where req[i] & gnt[i];
  // gnt is combinational from req/hold/state, so req must be held until granted,
  // and rsp_valid[i] is a one-cycle strobe with no back-pressure.

  rdarb_state_e       state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] gnt_c;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    next_ptr;
  logic               accept;
  logic               last_beat;

  logic               tag_valid;
  logic [ID_W-1:0]    tag_id;
  logic               tag_any;

  assign pick = NUM_REQ'(rr_pick(RDARB_MAX_REQ'(req), 2'(ptr_q), NUM_REQ));

  // Grants are suppressed while reset is asserted or the pipeline is held.
  always_comb begin
    gnt_c = '0;
    if (!rd_rst && !hold) begin
      if (state_q == ST_IDLE) begin
        gnt_c = pick;
      end else begin
        gnt_c[owner_q] = req[owner_q];
      end
    end
  end

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        gnt_id = ID_W'(i);
      end
    end
  end

  assign accept    = |gnt_c;
  assign last_beat = |(gnt_c & req_last);
  assign next_ptr  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (accept) begin
      owner_d = gnt_id;
      if (last_beat) begin
        state_d = ST_IDLE;
        ptr_d   = next_ptr;
      end else begin
        state_d = ST_LOCK;
      end
    end
  end

  // The RAM keeps seeing the last issued address while nothing is granted.
  always_comb begin
    ram_rd_addr = addr_q;
    if (accept) begin
      ram_rd_addr = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
    end
    addr_d = ram_rd_addr;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
    end
  end

  ipsxe_fft_rdarb_tagpipe #(
    .DEPTH (RD_LATENCY),
    .ID_W  (ID_W)
  ) u_tagpipe (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .adv       (~hold),
    .in_valid  (accept),
    .in_id     (gnt_id),
    .out_valid (tag_valid),
    .out_id    (tag_id),
    .any_valid (tag_any)
  );

  always_comb begin
    rsp_valid = '0;
    if (tag_valid && !hold) begin
      rsp_valid[tag_id] = 1'b1;
    end
  end

  assign gnt           = gnt_c;
  assign rsp_data      = ram_rd_data;
  assign ram_rd_clk_en = ~hold & ~rd_rst;
  assign ram_rd_oce    = ~hold & ~rd_rst;
  assign busy          = (state_q == ST_LOCK) | tag_any;
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_ipsxe_fft_drm_rd_arbiter.sv
// Directed bench for the DRM read arbiter: a 2-requester instance against a
// behavioural SDPRAM with output register, plus a 3-requester instance for wrap.
module tb_ipsxe_fft_drm_rd_arbiter;
  import ipsxe_fft_rdarb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 36;

  // ---------------- clock / reset ----------------
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  always #5 rd_clk = ~rd_clk;

  // ---------------- 2-requester DUT ----------------
  logic              hold = 1'b0;
  logic [1:0]        req = '0;
  logic [1:0]        req_last = '0;
  logic [2*AW-1:0]   req_addr = '0;
  logic [1:0]        gnt;
  logic [AW-1:0]     ram_rd_addr;
  logic              ram_rd_clk_en;
  logic              ram_rd_oce;
  logic [DW-1:0]     ram_rd_data = '0;
  logic [1:0]        rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  rdarb_state_e      dbg_state;
  logic              dbg_ptr;

  ipsxe_fft_drm_rd_arbiter #(
    .NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .hold(hold), .req(req),
    .req_addr(req_addr), .req_last(req_last), .gnt(gnt),
    .ram_rd_addr(ram_rd_addr), .ram_rd_clk_en(ram_rd_clk_en),
    .ram_rd_oce(ram_rd_oce), .ram_rd_data(ram_rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // SDPRAM model: array read stage then fabric output register.
  logic [DW-1:0] mem [512];
  logic [DW-1:0] ram_arr_q = '0;
  always @(posedge rd_clk) begin
    if (ram_rd_clk_en) ram_arr_q <= mem[ram_rd_addr];
    if (ram_rd_oce)    ram_rd_data <= ram_arr_q;
  end

  // ---------------- 3-requester DUT (wrap) ----------------
  logic [2:0]      r3_req = '0;
  logic [2:0]      r3_last = '0;
  logic [3*AW-1:0] r3_addr = '0;
  logic [2:0]      r3_gnt;
  logic [AW-1:0]   r3_ram_addr;
  logic            r3_clk_en;
  logic            r3_oce;
  logic [DW-1:0]   r3_rd_data = '0;
  logic [2:0]      r3_rsp_valid;
  logic [DW-1:0]   r3_rsp_data;
  logic            r3_busy;
  rdarb_state_e    r3_state;
  logic [1:0]      r3_ptr;

  ipsxe_fft_drm_rd_arbiter #(
    .NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)
  ) dut3 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .hold(1'b0), .req(r3_req),
    .req_addr(r3_addr), .req_last(r3_last), .gnt(r3_gnt),
    .ram_rd_addr(r3_ram_addr), .ram_rd_clk_en(r3_clk_en),
    .ram_rd_oce(r3_oce), .ram_rd_data(r3_rd_data),
    .rsp_valid(r3_rsp_valid), .rsp_data(r3_rsp_data), .busy(r3_busy),
    .dbg_state(r3_state), .dbg_ptr(r3_ptr)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: {rsp_valid one-hot, data} in issue order.
  logic [37:0] exp_q[$];

  task automatic push_exp(input logic [1:0] id, input logic [AW-1:0] addr);
    exp_q.push_back({id, mem[addr]});
  endtask

  always @(negedge rd_clk) begin
    if (rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) chk_eq("rsp_unexpected", 64'(rsp_valid), 64'(0));
      else chk_eq("rsp_word", 64'({rsp_valid, rsp_data}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic at_mid();
    @(negedge rd_clk);
  endtask

  task automatic pulse_reset();
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
  endtask

  // ---------------- stimulus tables ----------------
  logic [1:0] rr_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  logic [1:0]   b_req  [7] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00};
  logic [1:0]   b_last [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
  logic [8:0]   b_a1   [7] = '{9'h100, 9'h101, 9'h101, 9'h102, 9'h103, 9'h103, 9'h103};
  logic [1:0]   b_gnt  [7] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
  rdarb_state_e b_st   [7] = '{ST_IDLE, ST_LOCK, ST_LOCK, ST_LOCK, ST_LOCK, ST_IDLE, ST_IDLE};

  logic       h_hold [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] h_req  [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
  logic [1:0] h_gnt  [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] h_rsp  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

  logic [2:0] w_req  [5] = '{3'b100, 3'b100, 3'b111, 3'b101, 3'b101};
  logic [2:0] w_last [5] = '{3'b000, 3'b100, 3'b111, 3'b111, 3'b111};
  logic [2:0] w_gnt  [5] = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b001};
  logic [1:0] w_ptr  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 36'(i) * 36'h0_0100_0011 + 36'h3;
    mem[9'h05A] = 36'h1_2345_6789;

    // Reset state, with requests already pending.
    rd_rst = 1'b1; req = 2'b11; req_last = 2'b11; r3_req = 3'b111;
    at_mid();
    chk_eq("rst_gnt",    64'(gnt), 64'(0));
    chk_eq("rst_gnt3",   64'(r3_gnt), 64'(0));
    chk_eq("rst_rsp",    64'(rsp_valid), 64'(0));
    chk_eq("rst_busy",   64'(busy), 64'(0));
    chk_eq("rst_clk_en", 64'(ram_rd_clk_en), 64'(0));
    chk_eq("rst_oce",    64'(ram_rd_oce), 64'(0));
    chk_eq("rst_addr",   64'(ram_rd_addr), 64'(0));
    chk_eq("rst_state",  64'(dbg_state), 64'(ST_IDLE));
    chk_eq("rst_ptr",    64'(dbg_ptr), 64'(0));
    tick();
    rd_rst = 1'b0; req = '0; r3_req = '0; req_last = '0;

    // Single read.
    req = 2'b01; req_last = 2'b01; req_addr[AW-1:0] = 9'h05A;
    push_exp(2'b01, 9'h05A);
    at_mid();
    chk_eq("single_gnt",  64'(gnt), 64'(2'b01));
    chk_eq("single_addr", 64'(ram_rd_addr), 64'(9'h05A));
    chk_eq("single_en",   64'(ram_rd_clk_en), 64'(1));
    tick(); req = '0;
    at_mid();
    chk_eq("single_c1_rsp",  64'(rsp_valid), 64'(0));
    chk_eq("single_c1_busy", 64'(busy), 64'(1));
    tick(); at_mid();
    chk_eq("single_c2_rsp",  64'(rsp_valid), 64'(2'b01));
    chk_eq("single_c2_data", 64'(rsp_data), 64'(36'h1_2345_6789));
    tick(); at_mid();
    chk_eq("single_c3_busy", 64'(busy), 64'(0));
    chk_eq("addr_holds",     64'(ram_rd_addr), 64'(9'h05A));
    chk_eq("single_ptr",     64'(dbg_ptr), 64'(1));
    tick();
    pulse_reset();
    at_mid();
    chk_eq("rr_ptr_after_rst", 64'(dbg_ptr), 64'(0));
    tick();

    // Round robin with single-beat reads from both requesters.
    for (int n = 0; n < 6; n++) begin
      if (n < 4) begin
        req = 2'b11; req_last = 2'b11;
        req_addr = {9'(9'h020 + n), 9'(9'h010 + n)};
        push_exp(rr_seq[n], (rr_seq[n] == 2'b01) ? 9'(9'h010 + n) : 9'(9'h020 + n));
      end else begin
        req = '0;
      end
      at_mid();
      if (n < 4)  chk_eq("rr_gnt", 64'(gnt), 64'(rr_seq[n]));
      if (n >= 2) chk_eq("rr_rsp", 64'(rsp_valid), 64'(rr_seq[n-2]));
      tick();
    end

    // Burst lock by requester 1 while requester 0 waits; lock survives a req gap.
    req_addr[AW-1:0] = 9'h050;
    for (int n = 0; n < 7; n++) begin
      req = b_req[n]; req_last = b_last[n]; req_addr[2*AW-1:AW] = b_a1[n];
      if (b_gnt[n] == 2'b10) push_exp(2'b10, b_a1[n]);
      if (b_gnt[n] == 2'b01) push_exp(2'b01, 9'h050);
      at_mid();
      chk_eq("burst_gnt",   64'(gnt), 64'(b_gnt[n]));
      chk_eq("burst_state", 64'(dbg_state), 64'(b_st[n]));
      tick();
    end
    for (int n = 0; n < 3; n++) tick();
    chk_eq("burst_drain", 64'(exp_q.size()), 64'(0));

    // Hold freezes grants, enables and the tag pipeline.
    req_addr[AW-1:0] = 9'h077;
    for (int n = 0; n < 6; n++) begin
      hold = h_hold[n]; req = h_req[n]; req_last = h_req[n];
      if (h_gnt[n] == 2'b01) push_exp(2'b01, 9'h077);
      at_mid();
      chk_eq("hold_gnt", 64'(gnt), 64'(h_gnt[n]));
      chk_eq("hold_en",  64'({ram_rd_clk_en, ram_rd_oce}), 64'({~h_hold[n], ~h_hold[n]}));
      chk_eq("hold_rsp", 64'(rsp_valid), 64'(h_rsp[n]));
      tick();
    end
    hold = 1'b0; req = '0;
    tick();

    // Reset with two reads in flight: they must never respond.
    req = 2'b01; req_last = 2'b01; req_addr = {9'h031, 9'h030};
    at_mid();
    chk_eq("rstf_gnt0", 64'(gnt), 64'(2'b01));
    tick();
    req = 2'b10; req_last = 2'b10;
    at_mid();
    chk_eq("rstf_gnt1", 64'(gnt), 64'(2'b10));
    tick();
    rd_rst = 1'b1; req = 2'b11; req_last = 2'b11;
    at_mid();
    chk_eq("rstf_gnt_in_rst", 64'(gnt), 64'(0));
    chk_eq("rstf_rsp_in_rst", 64'(rsp_valid), 64'(0));
    tick();
    rd_rst = 1'b0; req = '0;
    at_mid();
    chk_eq("rstf_state", 64'(dbg_state), 64'(ST_IDLE));
    chk_eq("rstf_ptr",   64'(dbg_ptr), 64'(0));
    chk_eq("rstf_busy",  64'(busy), 64'(0));
    for (int n = 0; n < 3; n++) begin
      tick(); at_mid();
      chk_eq("rstf_no_rsp", 64'(rsp_valid), 64'(0));
    end
    tick();

    // Pointer wrap on the 3-requester instance.
    for (int n = 0; n < 5; n++) begin
      r3_req = w_req[n]; r3_last = w_last[n];
      at_mid();
      chk_eq("wrap_ptr", 64'(r3_ptr), 64'(w_ptr[n]));
      chk_eq("wrap_gnt", 64'(r3_gnt), 64'(w_gnt[n]));
      if (n == 1) chk_eq("wrap_busy", 64'(r3_busy), 64'(1));
      if (n == 2) chk_eq("wrap_rsp",  64'(r3_rsp_valid), 64'(3'b100));
      tick();
    end
    r3_req = '0;
    tick();

    chk_eq("final_drain", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
